// File: rtl/definitions.sv
// Shared ALU definitions: instruction word, opcodes and issue-queue FSM states.
package definitions;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    PASS = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t    op;
    logic [7:0] a;
    logic [7:0] b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } issue_state_t;

endpackage

// File: rtl/issue_fifo.sv
// Show-ahead FIFO holding {instruction, tag} entries for the ALU issue queue.
// The head entry is always visible on rd_data; clear has priority over push/pop.
module issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage write; entries need no reset since count gates their use.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers decoded instructions, issues one per cycle to the
// ALU with a wrapping tag, and produces a result strobe aligned with the ALU's
// registered result. Owns ALU stall (hold), flush and multiplier pacing.
// Optional feature macro: ALU_ISSUE_MUL_BUBBLE_EN inserts one idle issue slot
// after every MUL.
module alu_issue_queue
  import definitions::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  instruction_t               in_iw,
  input  logic                       flush,
  input  logic                       hold,
  output instruction_t               iw_out,
  output logic                       issue,
  output logic [TAG_W-1:0]           issue_tag,
  output logic                       res_valid,
  output logic [TAG_W-1:0]           res_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned IW_W  = $bits(instruction_t);
  localparam int unsigned ENT_W = IW_W + TAG_W;

  logic [TAG_W-1:0] tag_cnt;
  logic [ENT_W-1:0] head;
  instruction_t     head_iw;
  logic [TAG_W-1:0] head_tag;
  logic             push;
  logic             pop;
  logic             gate_open;
  logic [CNT_W-1:0] cnt_next;
  issue_state_t     state;
  issue_state_t     state_next;

  assign head_iw  = head[ENT_W-1:TAG_W];
  assign head_tag = head[TAG_W-1:0];

  // A full queue refuses pushes regardless of a same-cycle pop.
  assign in_ready = (count < CNT_W'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

`ifdef ALU_ISSUE_MUL_BUBBLE_EN
  // Give the multiplier a spare cycle: close the gate for one edge after a MUL issue.
  assign gate_open = !(issue && (iw_out.op == MUL));
`else
  assign gate_open = 1'b1;
`endif

  assign pop      = (count != '0) && !hold && !flush && gate_open;
  assign cnt_next = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));

  issue_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .wr_data ({in_iw, tag_cnt}),
    .rd_data (head),
    .count   (count)
  );

  // Tag counter advances per accepted push and survives flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_cnt <= '0;
    end else if (push) begin
      tag_cnt <= TAG_W'(tag_cnt + 1'b1);
    end
  end

  // Issue registers plus one-cycle result strobe matching the ALU's result register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue     <= 1'b0;
      iw_out    <= '0;
      issue_tag <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
    end else begin
      issue <= pop;
      if (pop) begin
        iw_out    <= head_iw;
        issue_tag <= head_tag;
      end
      res_valid <= issue;
      res_tag   <= issue_tag;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: flush overrides everything, otherwise track occupancy and hold.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (push) state_next = ISSUE;
      ISSUE: begin
        if (cnt_next == '0) state_next = IDLE;
        else if (hold)      state_next = STALL;
      end
      STALL: begin
        if (cnt_next == '0) state_next = IDLE;
        else if (!hold)     state_next = ISSUE;
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = FLUSH;
  end

endmodule
